fmap_pingpong_buffer: RTL
=========================

# fmap_pingpong_buffer

Double-buffered feature-map store between the layer-1 conv/max-pool pipeline (14x14 signed 8-bit output stream, no backpressure) and the layer-2 convolution input. Captures each full frame into one of two banks while the other bank is replayed downstream with valid/ready flow control, so layer 1 can start its next image while layer 2 still consumes the previous one. Reports overflow and short-frame errors as sticky flags.

## Interface
- MAPSIZE, 14, frame side length; frame = MAPSIZE*MAPSIZE pixels (196)
- DATA_W, 8, pixel width, signed two's complement

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input pixel strobe (layer-1 data_valid_out)
- in_pixel  in  DATA_W  signed input pixel, raster order
- in_done  in  1  end-of-frame pulse from upstream (layer-1 layer_done)
- out_ready  in  1  downstream accepts pixel this cycle
- err_clr  in  1  synchronous clear of sticky error flags
- out_valid  out  1  out_pixel valid
- out_pixel  out  DATA_W  signed output pixel, raster order
- out_last  out  1  qualifies final pixel (index MAPSIZE*MAPSIZE-1) of a frame
- out_frame_start  out  1  one-cycle pulse before first pixel of each replayed frame
- bank_full  out  2  per-bank full status, bit b = bank b holds an unread frame
- overflow  out  1  sticky: pixel arrived while write bank full
- frame_err  out  1  sticky: in_done arrived with partial frame

## Operation
- Reset: all outputs 0; bank_full=2'b00; write bank=0, read bank=0; write count=0; read FSM IDLE. Bank contents undefined.
- Write side: on in_valid, if bank_full[wbank]=0, store in_pixel at bank[wbank][wcnt], wcnt++. On write of index MAPSIZE*MAPSIZE-1: set bank_full[wbank], toggle wbank, wcnt=0.
- If in_valid while bank_full[wbank]=1: pixel dropped, overflow set, wcnt unchanged.
- in_done with wcnt=0: no effect (normal end after full frame). in_done with 0<wcnt: frame_err set, wcnt=0, bank not marked full (partial discarded). in_done coincident with in_valid: pixel processed first, then in_done evaluated on resulting count.
- Read FSM states: IDLE, START, STREAM.
  - IDLE: if bank_full[rbank]=1 -> START.
  - START: out_frame_start=1 for exactly this cycle; rcnt=0; issue read of index 0 -> STREAM.
  - STREAM: out_valid held with stable out_pixel until out_valid&&out_ready. On handshake of index MAPSIZE*MAPSIZE-1 (out_last=1): clear bank_full[rbank], toggle rbank -> IDLE.
- Banks strictly alternate on both sides; frames replayed in arrival order.
- Set of bank_full by writer and clear by reader in same cycle on different banks: both take effect. Same bank cannot be both (writer blocked while full).
- err_clr clears overflow and frame_err; a set event in the same cycle wins.
- Widths: wcnt, rcnt are $clog2(MAPSIZE*MAPSIZE) bits; pixels stored verbatim, no arithmetic.

## Timing
- Bank becomes full on edge E (last pixel written); reader in IDLE sees it at E+1 -> out_frame_start high cycle E+1..E+2 window exactly one cycle; first out_valid asserted at E+3 latest.
- With out_ready held 1: one pixel per cycle, frame replay takes MAPSIZE*MAPSIZE consecutive valid cycles, no bubbles.
- Back-to-back frames: after last handshake, IDLE->START->STREAM adds 2 idle cycles (out_valid=0) before next frame's first pixel.
- out_valid must not drop without a handshake; out_pixel/out_last stable while out_valid&&!out_ready.
- Write side accepts one pixel per cycle unconditionally (no upstream ready).
- rst mid-frame: immediate return to reset state; out_valid drops asynchronously; partial data discarded.

## Test plan
- Single frame: stream 196 pixels (value = index-98), out_ready=1 -> one out_frame_start, 196 out_valid beats matching input in order, out_last on beat 196 only, bank_full returns 00.
- Backpressure: same frame, out_ready toggled pseudo-randomly -> identical output sequence, out_pixel stable during stalls, no drops or duplicates.
- Ping-pong: three consecutive frames (A, B, C) with out_ready=0 until C starts -> A, B stored (bank_full=11), C pixels set overflow and are dropped; release ready -> A then B replayed exactly.
- Short frame: 100 pixels then in_done -> frame_err=1, nothing replayed; next full 196-pixel frame replayed correctly into same bank; err_clr -> frame_err=0.
- Concurrent read/write: frame 2 written while frame 1 drains at ready=1 -> both frames correct, bank_full never 11 glitch-free transitions verified.
- Reset mid-stream: assert rst at pixel 50 of replay -> all outputs 0 immediately; subsequent fresh frame replays from bank 0 correctly.

Source files
------------

// File: rtl/fmap_pingpong_buffer_if.sv
// Signal bundle for fmap_pingpong_buffer: raw layer-1 pixel stream in,
// valid/ready replay stream out, plus bank status and sticky error flags.
interface fmap_pingpong_buffer_if #(
  parameter int DATA_W = 8
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_pixel;
  logic                     in_done;
  logic                     out_ready;
  logic                     err_clr;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_pixel;
  logic                     out_last;
  logic                     out_frame_start;
  logic [1:0]               bank_full;
  logic                     overflow;
  logic                     frame_err;

  modport slave (
    input  in_valid, in_pixel, in_done, out_ready, err_clr,
    output out_valid, out_pixel, out_last, out_frame_start,
           bank_full, overflow, frame_err
  );

  modport master (
    output in_valid, in_pixel, in_done, out_ready, err_clr,
    input  out_valid, out_pixel, out_last, out_frame_start,
           bank_full, overflow, frame_err
  );
endinterface

// File: rtl/fmap_pingpong_buffer.sv
// Two-bank feature-map store: one bank captures the incoming frame while the
// other replays a completed frame downstream under valid/ready control.
module fmap_pingpong_buffer #(
  parameter int MAPSIZE = 14,
  parameter int DATA_W  = 8
) (
  input logic                   clk,
  input logic                   rst,
  fmap_pingpong_buffer_if.slave bus
);
  localparam int DEPTH = MAPSIZE * MAPSIZE;
  localparam int CNT_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_START  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  logic signed [DATA_W-1:0] mem [2][DEPTH];

  logic                     wbank_q, wbank_d;
  logic [CNT_W-1:0]         wcnt_q, wcnt_d;
  logic                     rbank_q, rbank_d;
  logic [CNT_W-1:0]         rcnt_q, rcnt_d;
  logic [1:0]               bank_full_q, bank_full_d;
  logic [1:0]               state_q, state_d;
  logic signed [DATA_W-1:0] out_pixel_q, out_pixel_d;
  logic                     overflow_q, overflow_d;
  logic                     frame_err_q, frame_err_d;

  logic                     wr_en;
  logic                     wr_last;
  logic                     rd_last_hs;
  logic [CNT_W-1:0]         rd_addr;

  // Writer: the pixel is accounted for first, then in_done judges the count it left behind.
  always_comb begin
    wr_en       = bus.in_valid && !bank_full_q[wbank_q];
    wr_last     = wr_en && (wcnt_q == LAST_IDX);
    wbank_d     = wbank_q;
    wcnt_d      = wcnt_q;
    overflow_d  = bus.err_clr ? 1'b0 : overflow_q;
    frame_err_d = bus.err_clr ? 1'b0 : frame_err_q;

    if (bus.in_valid && bank_full_q[wbank_q]) begin
      overflow_d = 1'b1;
    end

    if (wr_last) begin
      wcnt_d  = '0;
      wbank_d = ~wbank_q;
    end else if (wr_en) begin
      wcnt_d = wcnt_q + CNT_ONE;
    end

    if (bus.in_done && (wcnt_d != '0)) begin
      frame_err_d = 1'b1;
      wcnt_d      = '0;
    end
  end

  // Reader: out_pixel is registered, so the next address is fetched on the handshake.
  always_comb begin
    state_d     = state_q;
    rbank_d     = rbank_q;
    rcnt_d      = rcnt_q;
    out_pixel_d = out_pixel_q;
    rd_addr     = '0;
    rd_last_hs  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bank_full_q[rbank_q]) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        rcnt_d      = '0;
        out_pixel_d = mem[rbank_q][rd_addr];
        state_d     = ST_STREAM;
      end
      ST_STREAM: begin
        if (bus.out_ready) begin
          if (rcnt_q == LAST_IDX) begin
            rd_last_hs = 1'b1;
            rbank_d    = ~rbank_q;
            state_d    = ST_IDLE;
          end else begin
            rd_addr     = rcnt_q + CNT_ONE;
            rcnt_d      = rd_addr;
            out_pixel_d = mem[rbank_q][rd_addr];
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Writer and reader never own the same bank, so both updates can land together.
  always_comb begin
    bank_full_d = bank_full_q;
    if (wr_last) begin
      bank_full_d[wbank_q] = 1'b1;
    end
    if (rd_last_hs) begin
      bank_full_d[rbank_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wbank_q][wcnt_q] <= bus.in_pixel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbank_q     <= 1'b0;
      wcnt_q      <= '0;
      rbank_q     <= 1'b0;
      rcnt_q      <= '0;
      bank_full_q <= 2'b00;
      state_q     <= ST_IDLE;
      out_pixel_q <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wbank_q     <= wbank_d;
      wcnt_q      <= wcnt_d;
      rbank_q     <= rbank_d;
      rcnt_q      <= rcnt_d;
      bank_full_q <= bank_full_d;
      state_q     <= state_d;
      out_pixel_q <= out_pixel_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.out_valid       = (state_q == ST_STREAM);
  assign bus.out_frame_start = (state_q == ST_START);
  assign bus.out_last        = (state_q == ST_STREAM) && (rcnt_q == LAST_IDX);
  assign bus.out_pixel       = out_pixel_q;
  assign bus.bank_full       = bank_full_q;
  assign bus.overflow        = overflow_q;
  assign bus.frame_err       = frame_err_q;

endmodule
